// File: rtl/ibus_mem_responder_pkg.sv
// ibus_mem_responder_pkg
// Shared types for the instruction-bus responder: FSM state encoding,
// the line-buffer entry layout and fetch-group sizing constants.
package ibus_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR0 = 3'd1,
        ST_DATA0 = 3'd2,
        ST_ADDR1 = 3'd3,
        ST_DATA1 = 3'd4,
        ST_RESP  = 3'd5,
        ST_DRAIN = 3'd6
    } ibus_resp_state_t;

    localparam int unsigned IBUS_FETCH_BYTES = 8;
    localparam int unsigned IBUS_WORD_BYTES  = 4;
    localparam int unsigned IBUS_FETCH_W     = IBUS_FETCH_BYTES * 8;
    localparam int unsigned IBUS_TAG_W       = 30;

    typedef struct packed {
        logic                    valid;
        logic [IBUS_TAG_W-1:0]   tag;
        logic [IBUS_FETCH_W-1:0] data;
    } ibus_line_buf_t;

endpackage

// File: rtl/ibus_mem_responder_line_buf.sv
// ibus_line_buf
// One-entry fetch-group buffer: tag compare against the incoming request and
// a write/invalidate port. Invalidation wins over a same-cycle write.
// Ports:
//   clk, rst      clock, synchronous active-high reset (entry invalid)
//   lookup_tag    address[31:2] of the request being looked up
//   hit, rd_data  lookup result and the buffered 64-bit group
//   wr_en, wr_tag, wr_data  fill the entry
//   inv           drop the entry
module ibus_line_buf
    import ibus_mem_responder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IBUS_TAG_W-1:0]   lookup_tag,
    output logic                    hit,
    output logic [IBUS_FETCH_W-1:0] rd_data,
    input  logic                    wr_en,
    input  logic [IBUS_TAG_W-1:0]   wr_tag,
    input  logic [IBUS_FETCH_W-1:0] wr_data,
    input  logic                    inv
);

    ibus_line_buf_t buf_q, buf_d;

    always_comb begin
        buf_d = buf_q;
        if (inv) begin
            buf_d.valid = 1'b0;
        end else if (wr_en) begin
            buf_d.valid = 1'b1;
            buf_d.tag   = wr_tag;
            buf_d.data  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign hit     = buf_q.valid && (buf_q.tag == lookup_tag);
    assign rd_data = buf_q.data;

endmodule

// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder
// Responder end of the instruction-fetch bus. A fetch request is turned into
// two sequential single-word reads on the memory port (addr, addr+4) and
// returned as one 64-bit group {word1, word0} with a one-cycle valid strobe.
// Optional feature macro: IBUS_RESP_LINE_BUF_EN adds a one-entry line buffer
// that answers repeat requests without touching memory.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ibus_read, ibus_address   fetch request and byte address
//   ibus_flush                cancel in-flight fetch
//   ibus_inv_buf              invalidate line buffer (ignored without buffer)
//   ibus_stall                busy
//   ibus_valid, ibus_rddata, ibus_err   response
//   mem_req, mem_addr, mem_ready        memory request handshake
//   mem_rvalid, mem_rdata, mem_rerr     memory read return
module ibus_mem_responder
    import ibus_mem_responder_pkg::*;
#(
    parameter int MEM_ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ibus_read,
    input  logic [31:0]             ibus_address,
    input  logic                    ibus_flush,
    input  logic                    ibus_inv_buf,
    output logic                    ibus_stall,
    output logic                    ibus_valid,
    output logic [IBUS_FETCH_W-1:0] ibus_rddata,
    output logic                    ibus_err,
    output logic                    mem_req,
    output logic [MEM_ADDR_W-1:0]   mem_addr,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_rerr
);

    ibus_resp_state_t        state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [IBUS_FETCH_W-1:0] rddata_q, rddata_d;
    logic                    err_q, err_d;

    logic                    lb_hit;
    logic [IBUS_FETCH_W-1:0] lb_data;
    logic                    lb_wr_en;
    logic [31:0]             addr_plus4;
    logic [31:0]             mem_addr_full;

`ifdef IBUS_RESP_LINE_BUF_EN
    // Only a response that actually reaches the fetch stage error-free is cached.
    assign lb_wr_en = (state_q == ST_RESP) && !err_q && !ibus_flush;

    ibus_line_buf u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (ibus_address[31:2]),
        .hit        (lb_hit),
        .rd_data    (lb_data),
        .wr_en      (lb_wr_en),
        .wr_tag     (addr_q[31:2]),
        .wr_data    (rddata_q),
        .inv        (ibus_inv_buf)
    );
`else
    logic unused_inv_buf;
    assign unused_inv_buf = ibus_inv_buf;
    assign lb_wr_en       = 1'b0;
    assign lb_hit         = 1'b0;
    assign lb_data        = '0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rddata_d = rddata_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                // A flush in IDLE also blocks a same-cycle request.
                if (ibus_read && !ibus_flush) begin
                    addr_d = ibus_address;
                    if (ibus_address[1:0] != 2'b00) begin
                        err_d    = 1'b1;
                        rddata_d = '0;
                        state_d  = ST_RESP;
                    end else if (lb_hit) begin
                        err_d    = 1'b0;
                        rddata_d = lb_data;
                        state_d  = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ADDR0;
                    end
                end
            end
            ST_ADDR0, ST_ADDR1: begin
                if (ibus_flush) begin
                    // An accepted request still owes us a beat; absorb it.
                    state_d = mem_ready ? ST_DRAIN : ST_IDLE;
                end else if (mem_ready) begin
                    state_d = (state_q == ST_ADDR0) ? ST_DATA0 : ST_DATA1;
                end
            end
            ST_DATA0: begin
                if (ibus_flush) begin
                    state_d = mem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid) begin
                    rddata_d[31:0] = mem_rdata;
                    err_d          = err_q | mem_rerr;
                    if (mem_rerr) begin
                        rddata_d[63:32] = '0;
                        state_d         = ST_RESP;
                    end else begin
                        state_d = ST_ADDR1;
                    end
                end
            end
            ST_DATA1: begin
                if (ibus_flush) begin
                    state_d = mem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid) begin
                    rddata_d[63:32] = mem_rdata;
                    err_d           = err_q | mem_rerr;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rddata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rddata_q <= rddata_d;
            err_q    <= err_d;
        end
    end

    // Second word address wraps modulo 2^32.
    assign addr_plus4    = addr_q + 32'(IBUS_WORD_BYTES);
    assign mem_addr_full = (state_q == ST_ADDR0) ? addr_q :
                           (state_q == ST_ADDR1) ? addr_plus4 : 32'h0;

    assign mem_req     = (state_q == ST_ADDR0) || (state_q == ST_ADDR1);
    assign mem_addr    = MEM_ADDR_W'(mem_addr_full);
    assign ibus_stall  = (state_q == ST_ADDR0) || (state_q == ST_DATA0) ||
                         (state_q == ST_ADDR1) || (state_q == ST_DATA1) ||
                         (state_q == ST_DRAIN);
    assign ibus_valid  = (state_q == ST_RESP) && !ibus_flush;
    assign ibus_rddata = rddata_q;
    assign ibus_err    = err_q;

endmodule

// File: tb/tb_ibus_mem_responder.sv
module tb_ibus_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_flush;
    logic        ibus_inv_buf;
    logic        ibus_stall;
    logic        ibus_valid;
    logic [63:0] ibus_rddata;
    logic        ibus_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rerr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ibus_mem_responder #(.MEM_ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ibus_read    (ibus_read),
        .ibus_address (ibus_address),
        .ibus_flush   (ibus_flush),
        .ibus_inv_buf (ibus_inv_buf),
        .ibus_stall   (ibus_stall),
        .ibus_valid   (ibus_valid),
        .ibus_rddata  (ibus_rddata),
        .ibus_err     (ibus_err),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_rerr     (mem_rerr)
    );

    // Memory contents: a few fixed words, everything else derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0104: return 32'h2222_2222;
            32'hFFFF_FFFC: return 32'hDEAD_BEEF;
            32'h0000_0000: return 32'hCAFE_F00D;
            32'h0000_0200: return 32'h3333_3333;
            32'h0000_0204: return 32'h4444_4444;
            32'h0000_0300: return 32'h5555_5555;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Memory model: read data returns mem_lat cycles after the accept edge.
    int          mem_lat = 1;
    logic        pend;
    int          wait_q;
    logic [31:0] pend_addr;
    int          hs_cnt = 0;
    logic [31:0] acc_addr [$];

    assign mem_rvalid = pend && (wait_q == 0);
    assign mem_rdata  = mem_rvalid ? mem_word(pend_addr) : 32'h0;
    assign mem_rerr   = mem_rvalid && (pend_addr == 32'h0000_0300);

    always @(posedge clk) begin
        if (rst) begin
            pend   <= 1'b0;
            wait_q <= 0;
        end else if (mem_req && mem_ready) begin
            pend      <= 1'b1;
            wait_q    <= mem_lat - 1;
            pend_addr <= mem_addr;
            hs_cnt    <= hs_cnt + 1;
            acc_addr.push_back(mem_addr);
        end else if (pend) begin
            if (wait_q == 0) pend <= 1'b0;
            else             wait_q <= wait_q - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a);
        @(negedge clk);
        ibus_read    = 1'b1;
        ibus_address = a;
        @(posedge clk);
        #1;
        ibus_read = 1'b0;
    endtask

    // Latency counts sampling points after the request edge; -1 means timeout.
    task automatic wait_valid(output int lat, output logic [63:0] d, output logic e);
        lat = -1;
        d   = '0;
        e   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ibus_valid === 1'b1) begin
                lat = i;
                d   = ibus_rddata;
                e   = ibus_err;
                break;
            end
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input int exp_lat,
                         input logic [63:0] exp_d, input logic exp_e, input int exp_hs);
        int          lat;
        logic [63:0] d;
        logic        e;
        int          hs0;
        hs0 = hs_cnt;
        issue(a);
        wait_valid(lat, d, e);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_err"}, {63'h0, e}, {63'h0, exp_e});
        chk({tag, "_handshakes"}, 64'(hs_cnt - hs0), 64'(exp_hs));
    endtask

    initial begin
        int nvalid;
        int n;
        rst          = 1'b1;
        ibus_read    = 1'b0;
        ibus_address = '0;
        ibus_flush   = 1'b0;
        ibus_inv_buf = 1'b0;
        mem_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {63'h0, ibus_stall}, 64'h0);
        chk("rst_valid", {63'h0, ibus_valid}, 64'h0);
        chk("rst_err", {63'h0, ibus_err}, 64'h0);
        chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
        chk("rst_rddata", ibus_rddata, 64'h0);
        chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
        rst = 1'b0;

        // Best case aligned fetch
        fetch("a100", 32'h0000_0100, 5, 64'h2222_2222_1111_1111, 1'b0, 2);
        n = acc_addr.size();
        chk("a100_addr0", {32'h0, acc_addr[n-2]}, 64'h0000_0100);
        chk("a100_addr1", {32'h0, acc_addr[n-1]}, 64'h0000_0104);

        // Misaligned: immediate error response, no memory traffic
        fetch("mis102", 32'h0000_0102, 1, 64'h0, 1'b1, 0);

        // Top-of-memory wrap
        fetch("wrap", 32'hFFFF_FFFC, 5, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 2);
        n = acc_addr.size();
        chk("wrap_addr0", {32'h0, acc_addr[n-2]}, 64'hFFFF_FFFC);
        chk("wrap_addr1", {32'h0, acc_addr[n-1]}, 64'h0000_0000);

        // Back-pressure then flush in DATA0 -> DRAIN absorbs the late beat
        n = hs_cnt;
        mem_ready = 1'b0;
        issue(32'h0000_0180);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_mem_req", {63'h0, mem_req}, 64'h1);
        end
        chk("bp_mem_addr", {32'h0, mem_addr}, 64'h0000_0180);
        mem_lat   = 3;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("data0_mem_req", {63'h0, mem_req}, 64'h0);
        chk("data0_stall", {63'h0, ibus_stall}, 64'h1);
        ibus_flush = 1'b1;
        @(negedge clk);
        ibus_flush = 1'b0;
        chk("drain_stall", {63'h0, ibus_stall}, 64'h1);
        chk("drain_mem_req", {63'h0, mem_req}, 64'h0);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ibus_valid === 1'b1) nvalid++;
        end
        chk("drain_no_valid", 64'(nvalid), 64'h0);
        chk("drain_idle_stall", {63'h0, ibus_stall}, 64'h0);
        chk("drain_handshakes", 64'(hs_cnt - n), 64'h1);
        mem_lat = 1;
        fetch("after_drain", 32'h0000_0200, 5, 64'h4444_4444_3333_3333, 1'b0, 2);

        // Error on word0: word1 skipped and forced to zero
        fetch("rerr", 32'h0000_0300, 3, 64'h0000_0000_5555_5555, 1'b1, 1);

`ifdef IBUS_RESP_LINE_BUF_EN
        fetch("lb_fill", 32'h0000_0100, 5, 64'h2222_2222_1111_1111, 1'b0, 2);
        fetch("lb_hit", 32'h0000_0100, 1, 64'h2222_2222_1111_1111, 1'b0, 0);
        @(negedge clk);
        ibus_inv_buf = 1'b1;
        @(negedge clk);
        ibus_inv_buf = 1'b0;
        fetch("lb_inv", 32'h0000_0100, 5, 64'h2222_2222_1111_1111, 1'b0, 2);
`else
        fetch("nobuf_1", 32'h0000_0100, 5, 64'h2222_2222_1111_1111, 1'b0, 2);
        fetch("nobuf_2", 32'h0000_0100, 5, 64'h2222_2222_1111_1111, 1'b0, 2);
        @(negedge clk);
        ibus_inv_buf = 1'b1;
        @(negedge clk);
        ibus_inv_buf = 1'b0;
        fetch("nobuf_inv", 32'h0000_0100, 5, 64'h2222_2222_1111_1111, 1'b0, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
